// File: rtl/ex_mem_register_if.sv
// Signal bundle between the EX stage, the EX/MEM pipeline register and the MEM stage.
// The slave modport is the register itself; the master modport is the surrounding pipeline.
interface ex_mem_register_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              stall;
  logic              flush;
  logic              ID_EX_valid;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] rt_data;
  logic [REG_W-1:0]  ID_EX_rt;
  logic [REG_W-1:0]  write_reg;
  logic              ID_EX_mem_read;
  logic              ID_EX_mem_write;
  logic              ID_EX_mem_to_reg;
  logic              ID_EX_reg_write;
  logic              sw_forward;
  logic [DATA_W-1:0] MEM_WB_write_data;

  logic              EX_MEM_valid;
  logic [DATA_W-1:0] EX_MEM_alu_result;
  logic [DATA_W-1:0] EX_MEM_rt_data;
  logic [REG_W-1:0]  EX_MEM_rt;
  logic [REG_W-1:0]  EX_MEM_rd;
  logic              EX_MEM_mem_read;
  logic              EX_MEM_mem_write;
  logic              EX_MEM_mem_to_reg;
  logic              EX_MEM_reg_write;
  logic [DATA_W-1:0] mem_write_data;
  logic [31:0]       fwd_count;

  modport slave (
    input  stall, flush, ID_EX_valid, alu_result, rt_data, ID_EX_rt, write_reg,
           ID_EX_mem_read, ID_EX_mem_write, ID_EX_mem_to_reg, ID_EX_reg_write,
           sw_forward, MEM_WB_write_data,
    output EX_MEM_valid, EX_MEM_alu_result, EX_MEM_rt_data, EX_MEM_rt, EX_MEM_rd,
           EX_MEM_mem_read, EX_MEM_mem_write, EX_MEM_mem_to_reg, EX_MEM_reg_write,
           mem_write_data, fwd_count
  );

  modport master (
    output stall, flush, ID_EX_valid, alu_result, rt_data, ID_EX_rt, write_reg,
           ID_EX_mem_read, ID_EX_mem_write, ID_EX_mem_to_reg, ID_EX_reg_write,
           sw_forward, MEM_WB_write_data,
    input  EX_MEM_valid, EX_MEM_alu_result, EX_MEM_rt_data, EX_MEM_rt, EX_MEM_rd,
           EX_MEM_mem_read, EX_MEM_mem_write, EX_MEM_mem_to_reg, EX_MEM_reg_write,
           mem_write_data, fwd_count
  );
endinterface

// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register with stall/flush and store-data forwarding from MEM/WB.
// Optional forwarded-store counter is built only when EX_MEM_FWD_CNT_EN is defined.
module ex_mem_register #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  ex_mem_register_if.slave    bus
);

  logic              valid_q;
  logic [DATA_W-1:0] alu_result_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [REG_W-1:0]  rt_q;
  logic [REG_W-1:0]  rd_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              mem_to_reg_q;
  logic              reg_write_q;

  // A stalled stage recaptures the forwarded value so the store survives MEM/WB retiring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      alu_result_q <= '0;
      rt_data_q    <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
    end else if (bus.flush) begin
      valid_q      <= 1'b0;
      alu_result_q <= '0;
      rt_data_q    <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
    end else if (bus.stall) begin
      if (bus.sw_forward) begin
        rt_data_q <= bus.MEM_WB_write_data;
      end
    end else begin
      valid_q      <= bus.ID_EX_valid;
      alu_result_q <= bus.alu_result;
      rt_data_q    <= bus.rt_data;
      rt_q         <= bus.ID_EX_rt;
      rd_q         <= bus.write_reg;
      mem_read_q   <= bus.ID_EX_valid & bus.ID_EX_mem_read;
      mem_write_q  <= bus.ID_EX_valid & bus.ID_EX_mem_write;
      mem_to_reg_q <= bus.ID_EX_valid & bus.ID_EX_mem_to_reg;
      reg_write_q  <= bus.ID_EX_valid & bus.ID_EX_reg_write;
    end
  end

  assign bus.EX_MEM_valid      = valid_q;
  assign bus.EX_MEM_alu_result = alu_result_q;
  assign bus.EX_MEM_rt_data    = rt_data_q;
  assign bus.EX_MEM_rt         = rt_q;
  assign bus.EX_MEM_rd         = rd_q;
  assign bus.EX_MEM_mem_read   = mem_read_q;
  assign bus.EX_MEM_mem_write  = mem_write_q;
  assign bus.EX_MEM_mem_to_reg = mem_to_reg_q;
  assign bus.EX_MEM_reg_write  = reg_write_q;
  assign bus.mem_write_data    = bus.sw_forward ? bus.MEM_WB_write_data : rt_data_q;

`ifdef EX_MEM_FWD_CNT_EN
  logic [31:0] fwd_cnt_q;

  // Counts stores that actually leave MEM with forwarded data; saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_cnt_q <= '0;
    end else if (valid_q && mem_write_q && bus.sw_forward && !bus.stall && !bus.flush
                 && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
      fwd_cnt_q <= fwd_cnt_q + 32'd1;
    end
  end

  assign bus.fwd_count = fwd_cnt_q;
`else
  assign bus.fwd_count = '0;
`endif

endmodule

// File: tb/tb_ex_mem_register.sv
// Directed, table-driven bench for ex_mem_register; hand sequences cover async reset,
// zero-latency forwarding and (with EX_MEM_FWD_CNT_EN) counter saturation.
module tb_ex_mem_register;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_mem_register_if #(.DATA_W(32), .REG_W(5)) bus ();
  ex_mem_register #(.DATA_W(32), .REG_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] alu;
    logic [31:0] rtd;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic [3:0]  ctl;    // {mem_read, mem_write, mem_to_reg, reg_write}
    logic        swf;
    logic [31:0] wb;
    logic        e_valid;
    logic [31:0] e_alu;
    logic [31:0] e_rtd;
    logic [4:0]  e_rt;
    logic [4:0]  e_rd;
    logic [3:0]  e_ctl;
    logic [31:0] e_mwd;
  } vec_t;

  vec_t        vecs [12];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] cnt_model;
  logic        prev_valid;
  logic        prev_mw;

  function automatic logic [31:0] expCnt();
`ifdef EX_MEM_FWD_CNT_EN
    return cnt_model;
`else
    return 32'h0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic driveInputs(input vec_t v);
    bus.stall             = v.stall;
    bus.flush             = v.flush;
    bus.ID_EX_valid       = v.id_valid;
    bus.alu_result        = v.alu;
    bus.rt_data           = v.rtd;
    bus.ID_EX_rt          = v.rt;
    bus.write_reg         = v.wr;
    bus.ID_EX_mem_read    = v.ctl[3];
    bus.ID_EX_mem_write   = v.ctl[2];
    bus.ID_EX_mem_to_reg  = v.ctl[1];
    bus.ID_EX_reg_write   = v.ctl[0];
    bus.sw_forward        = v.swf;
    bus.MEM_WB_write_data = v.wb;
  endtask

  // Drive at the falling edge, step the model over the rising edge, sample 1 time unit later.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    driveInputs(v);
    @(posedge clk);
    if (prev_valid && prev_mw && v.swf && !v.stall && !v.flush && cnt_model != 32'hFFFF_FFFF)
      cnt_model = cnt_model + 32'd1;
    prev_valid = v.e_valid;
    prev_mw    = v.e_ctl[2];
    #1;
  endtask

  task automatic checkVector(input int i, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", i);
    checkOutput({tag, ".valid"}, 32'(bus.EX_MEM_valid), 32'(v.e_valid));
    checkOutput({tag, ".alu"}, bus.EX_MEM_alu_result, v.e_alu);
    checkOutput({tag, ".rt_data"}, bus.EX_MEM_rt_data, v.e_rtd);
    checkOutput({tag, ".rt"}, 32'(bus.EX_MEM_rt), 32'(v.e_rt));
    checkOutput({tag, ".rd"}, 32'(bus.EX_MEM_rd), 32'(v.e_rd));
    checkOutput({tag, ".ctl"}, 32'({bus.EX_MEM_mem_read, bus.EX_MEM_mem_write,
                                    bus.EX_MEM_mem_to_reg, bus.EX_MEM_reg_write}), 32'(v.e_ctl));
    checkOutput({tag, ".mem_write_data"}, bus.mem_write_data, v.e_mwd);
    checkOutput({tag, ".fwd_count"}, bus.fwd_count, expCnt());
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h100, 32'hAA, 5'd3, 5'd0, 4'b0100, 1'b0, 32'h0,
                 1'b1, 32'h100, 32'hAA, 5'd3, 5'd0, 4'b0100, 32'hAA};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h200, 32'hBB, 5'd4, 5'd0, 4'b0100, 1'b1, 32'h55,
                 1'b1, 32'h200, 32'hBB, 5'd4, 5'd0, 4'b0100, 32'h55};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h300, 32'hCC, 5'd5, 5'd6, 4'b1011, 1'b1, 32'h77,
                 1'b1, 32'h200, 32'h77, 5'd4, 5'd0, 4'b0100, 32'h77};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h300, 32'hCC, 5'd5, 5'd6, 4'b1011, 1'b0, 32'h99,
                 1'b1, 32'h200, 32'h77, 5'd4, 5'd0, 4'b0100, 32'h77};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h400, 32'hDD, 5'd7, 5'd8, 4'b1111, 1'b0, 32'h0,
                 1'b0, 32'h400, 32'hDD, 5'd7, 5'd8, 4'b0000, 32'hDD};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h11, 5'd9, 5'd10, 4'b0011, 1'b1, 32'h66,
                 1'b1, 32'h1234_5678, 32'h11, 5'd9, 5'd10, 4'b0011, 32'h66};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h500, 32'hEE, 5'd1, 5'd0, 4'b0100, 1'b0, 32'h0,
                 1'b1, 32'h500, 32'hEE, 5'd1, 5'd0, 4'b0100, 32'hEE};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h900, 32'h33, 5'd11, 5'd12, 4'b1111, 1'b1, 32'h88,
                 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 4'b0000, 32'h88};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h600, 32'h0, 5'd2, 5'd2, 4'b1010, 1'b0, 32'h0,
                 1'b1, 32'h600, 32'h0, 5'd2, 5'd2, 4'b1010, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h700, 32'hF0, 5'd3, 5'd0, 4'b0100, 1'b0, 32'h0,
                 1'b1, 32'h700, 32'hF0, 5'd3, 5'd0, 4'b0100, 32'hF0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 4'b0000, 1'b1, 32'h42,
                 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 4'b0000, 32'h42};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'hABC, 32'hDEF, 5'd1, 5'd1, 4'b1111, 1'b0, 32'h0,
                 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 4'b0000, 32'h0};

    // Reset state
    cnt_model  = 32'h0;
    prev_valid = 1'b0;
    prev_mw    = 1'b0;
    rst        = 1'b1;
    v          = '{default: '0};
    driveInputs(v);
    #12;
    checkOutput("reset.valid", 32'(bus.EX_MEM_valid), 32'h0);
    checkOutput("reset.alu", bus.EX_MEM_alu_result, 32'h0);
    checkOutput("reset.rt_data", bus.EX_MEM_rt_data, 32'h0);
    checkOutput("reset.mem_write", 32'(bus.EX_MEM_mem_write), 32'h0);
    checkOutput("reset.mem_write_data", bus.mem_write_data, 32'h0);
    checkOutput("reset.fwd_count", bus.fwd_count, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end

    // Plain load, then the forward mux must react within the same cycle
    v = '{1'b0, 1'b0, 1'b1, 32'h100, 32'hAA, 5'd3, 5'd0, 4'b0100, 1'b0, 32'h0,
          1'b1, 32'h100, 32'hAA, 5'd3, 5'd0, 4'b0100, 32'hAA};
    applyStimulus(v);
    checkOutput("load.alu", bus.EX_MEM_alu_result, 32'h100);
    checkOutput("load.mem_write_data", bus.mem_write_data, 32'hAA);
    @(negedge clk);
    bus.sw_forward        = 1'b1;
    bus.MEM_WB_write_data = 32'h55;
    #1;
    checkOutput("fwd.comb_55", bus.mem_write_data, 32'h55);
    bus.MEM_WB_write_data = 32'h56;
    #1;
    checkOutput("fwd.comb_56", bus.mem_write_data, 32'h56);
    checkOutput("fwd.rt_data_kept", bus.EX_MEM_rt_data, 32'hAA);
    @(posedge clk);
    cnt_model = cnt_model + 32'd1;
    #1;
    checkOutput("fwd.fwd_count", bus.fwd_count, expCnt());

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    cnt_model  = 32'h0;
    prev_valid = 1'b0;
    prev_mw    = 1'b0;
    checkOutput("async_rst.valid", 32'(bus.EX_MEM_valid), 32'h0);
    checkOutput("async_rst.alu", bus.EX_MEM_alu_result, 32'h0);
    checkOutput("async_rst.rt_data", bus.EX_MEM_rt_data, 32'h0);
    checkOutput("async_rst.mem_write", 32'(bus.EX_MEM_mem_write), 32'h0);
    checkOutput("async_rst.fwd_count", bus.fwd_count, 32'h0);
    v = '{1'b0, 1'b0, 1'b1, 32'h321, 32'hC0, 5'd6, 5'd0, 4'b0100, 1'b0, 32'h0,
          1'b1, 32'h321, 32'hC0, 5'd6, 5'd0, 4'b0100, 32'hC0};
    @(negedge clk);
    rst = 1'b0;
    driveInputs(v);
    @(posedge clk);
    prev_valid = 1'b1;
    prev_mw    = 1'b1;
    #1;
    checkVector(100, v);

`ifdef EX_MEM_FWD_CNT_EN
    // Counter saturation from a preloaded near-maximum value
    force dut.fwd_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.fwd_cnt_q;
    cnt_model = 32'hFFFF_FFFE;
    v.swf   = 1'b1;
    v.wb    = 32'h5A;
    v.e_mwd = 32'h5A;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(v);
      checkOutput($sformatf("sat.step%0d", k), bus.fwd_count, 32'hFFFF_FFFF);
    end
    checkOutput("sat.model", cnt_model, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
